// File: rtl/gb_mem_pkg.sv
// Shared memory-map definitions for the VRAM/OAM arbiter and the OAM DMA engine.
package gb_mem_pkg;

  typedef enum logic [1:0] {
    HBLANK = 2'd0,
    VBLANK = 2'd1,
    SCAN   = 2'd2,
    DRAW   = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_WAIT  = 2'd1,
    DMA_READ  = 2'd2,
    DMA_WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] VRAM_BASE     = 16'h8000;
  localparam logic [15:0] VRAM_END      = 16'h9FFF;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [15:0] OAM_END       = 16'hFE9F;
  localparam logic [15:0] OAM_HOLE_BASE = 16'hFEA0;
  localparam logic [15:0] OAM_HOLE_END  = 16'hFEFF;
  localparam logic [15:0] DMA_REG       = 16'hFF46;

  // One-cycle read-return tag: which requester gets which RAM's data next cycle.
  typedef struct packed {
    logic cpu_vram;
    logic cpu_oam;
    logic cpu_blk;
    logic ppu_vram;
    logic ppu_oam;
    logic ppu_blk;
  } rd_tag_t;

  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies DMA_LEN bytes from {page,00} on the main bus into OAM,
// one byte every two cycles, restartable by a fresh trigger at any time.
module oam_dma_engine
  import gb_mem_pkg::*;
#(
  parameter int DMA_LEN         = 160,
  parameter int DMA_START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_trig,
  input  logic [7:0]  trig_page,
  output logic        dma_src_rd,
  output logic [15:0] dma_src_addr,
  input  logic [7:0]  dma_src_rdata,
  output logic        dma_oam_wr,
  output logic [7:0]  dma_oam_addr,
  output logic [7:0]  dma_oam_wdata,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
  localparam logic [7:0] WAIT_LAST = 8'(DMA_START_DELAY - 1);

  dma_state_t state, state_nxt;
  logic [7:0] idx;
  logic [7:0] src_page;
  logic [7:0] wait_cnt;

  // State register; async reset abandons any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DMA_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a trigger always restarts from WAIT.
  always_comb begin
    state_nxt = state;
    if (dma_trig) begin
      state_nxt = DMA_WAIT;
    end else begin
      case (state)
        DMA_IDLE:  state_nxt = DMA_IDLE;
        DMA_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = DMA_READ;
        DMA_READ:  state_nxt = DMA_WRITE;
        DMA_WRITE: state_nxt = (idx == LAST_IDX) ? DMA_IDLE : DMA_READ;
        default:   state_nxt = DMA_IDLE;
      endcase
    end
  end

  // Byte index, source page and start-delay counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 8'd0;
      src_page <= 8'd0;
      wait_cnt <= 8'd0;
    end else if (dma_trig) begin
      idx      <= 8'd0;
      src_page <= trig_page;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        DMA_WAIT:  wait_cnt <= wait_cnt + 8'd1;
        DMA_WRITE: idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
        default:   ;
      endcase
    end
  end

  // Strobes per state; a restart landing on a WRITE cycle drops that byte.
  always_comb begin
    dma_src_rd    = 1'b0;
    dma_src_addr  = 16'h0000;
    dma_oam_wr    = 1'b0;
    dma_oam_addr  = 8'h00;
    dma_oam_wdata = 8'h00;
    case (state)
      DMA_READ: begin
        dma_src_rd   = 1'b1;
        dma_src_addr = {src_page, idx};
      end
      DMA_WRITE: begin
        dma_oam_wr    = !dma_trig;
        dma_oam_addr  = idx;
        dma_oam_wdata = dma_src_rdata;
      end
      default: ;
    endcase
    dma_active = (state != DMA_IDLE);
  end

endmodule

// File: rtl/vram_oam_arbiter.sv
// VRAM/OAM port arbiter: PPU-mode lockout, DMA > PPU > CPU per-port priority,
// and a one-cycle tag that steers synchronous RAM data back to the requester.
module vram_oam_arbiter
  import gb_mem_pkg::*;
#(
  parameter int         DMA_LEN         = 160,
  parameter int         DMA_START_DELAY = 1,
  parameter logic [7:0] BLOCKED_DATA    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_en,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        dma_src_rd,
  output logic [15:0] dma_src_addr,
  input  logic [7:0]  dma_src_rdata,
  output logic        dma_active,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_rd,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata
);

  ppu_mode_t  mode;
  logic       dma_trig;
  logic       dma_oam_wr;
  logic [7:0] dma_oam_addr;
  logic [7:0] dma_oam_wdata;

  logic cpu_req, cpu_in_vram, cpu_in_oam, cpu_in_hole;
  logic ppu_in_vram, ppu_in_oam;
  logic lock_vram, lock_oam;
  logic ppu_vram_g, ppu_oam_g, cpu_vram_g, cpu_oam_g;

  rd_tag_t    tag_nxt, tag_p1;
  logic [7:0] cpu_hold_p1, ppu_hold_p1;

  assign mode     = ppu_mode_t'(ppu_mode);
  assign dma_trig = cpu_wr && (cpu_addr == DMA_REG);

  oam_dma_engine #(
    .DMA_LEN         (DMA_LEN),
    .DMA_START_DELAY (DMA_START_DELAY)
  ) u_dma (
    .clk           (clk),
    .rst           (rst),
    .dma_trig      (dma_trig),
    .trig_page     (cpu_wdata),
    .dma_src_rd    (dma_src_rd),
    .dma_src_addr  (dma_src_addr),
    .dma_src_rdata (dma_src_rdata),
    .dma_oam_wr    (dma_oam_wr),
    .dma_oam_addr  (dma_oam_addr),
    .dma_oam_wdata (dma_oam_wdata),
    .dma_active    (dma_active)
  );

  // Lockout and grant decisions; everything is held off while reset is asserted.
  always_comb begin
    cpu_req     = cpu_rd || cpu_wr;
    cpu_in_vram = in_range(cpu_addr, VRAM_BASE, VRAM_END);
    cpu_in_oam  = in_range(cpu_addr, OAM_BASE, OAM_END);
    cpu_in_hole = in_range(cpu_addr, OAM_HOLE_BASE, OAM_HOLE_END);
    ppu_in_vram = in_range(ppu_addr, VRAM_BASE, VRAM_END);
    ppu_in_oam  = in_range(ppu_addr, OAM_BASE, OAM_END);
    lock_vram   = lcd_en && (mode == DRAW);
    lock_oam    = dma_active || (lcd_en && ((mode == SCAN) || (mode == DRAW)));
    ppu_vram_g  = !rst && lcd_en && ppu_rd && ppu_in_vram;
    ppu_oam_g   = !rst && lcd_en && ppu_rd && ppu_in_oam && !dma_active;
    cpu_vram_g  = !rst && cpu_req && cpu_in_vram && !lock_vram && !ppu_vram_g;
    cpu_oam_g   = !rst && cpu_req && cpu_in_oam && !lock_oam && !ppu_oam_g && !dma_oam_wr;
  end

  // RAM port muxes in priority order DMA > PPU > CPU.
  always_comb begin
    vram_addr  = 13'h0000;
    vram_rd    = 1'b0;
    vram_wr    = 1'b0;
    vram_wdata = 8'h00;
    oam_addr   = 8'h00;
    oam_rd     = 1'b0;
    oam_wr     = 1'b0;
    oam_wdata  = 8'h00;
    if (ppu_vram_g) begin
      vram_addr = ppu_addr[12:0];
      vram_rd   = 1'b1;
    end else if (cpu_vram_g) begin
      vram_addr  = cpu_addr[12:0];
      vram_rd    = cpu_rd;
      vram_wr    = cpu_wr;
      vram_wdata = cpu_wr ? cpu_wdata : 8'h00;
    end
    if (dma_oam_wr) begin
      oam_addr  = dma_oam_addr;
      oam_wr    = 1'b1;
      oam_wdata = dma_oam_wdata;
    end else if (ppu_oam_g) begin
      oam_addr = ppu_addr[7:0];
      oam_rd   = 1'b1;
    end else if (cpu_oam_g) begin
      oam_addr  = cpu_addr[7:0];
      oam_rd    = cpu_rd;
      oam_wr    = cpu_wr;
      oam_wdata = cpu_wr ? cpu_wdata : 8'h00;
    end
  end

  // Read-return tag for the next cycle; denied reads in our windows return BLOCKED_DATA.
  always_comb begin
    tag_nxt          = '0;
    tag_nxt.cpu_vram = cpu_vram_g && cpu_rd;
    tag_nxt.cpu_oam  = cpu_oam_g && cpu_rd;
    tag_nxt.cpu_blk  = !rst && cpu_rd && (cpu_in_vram || cpu_in_oam || cpu_in_hole)
                       && !cpu_vram_g && !cpu_oam_g;
    tag_nxt.ppu_vram = ppu_vram_g;
    tag_nxt.ppu_oam  = ppu_oam_g;
    tag_nxt.ppu_blk  = !rst && lcd_en && ppu_rd && !ppu_vram_g && !ppu_oam_g;
  end

  // ---- stage p1: tag and held read data ----
  // Tag register plus hold registers so read data persists between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_p1      <= '0;
      cpu_hold_p1 <= BLOCKED_DATA;
      ppu_hold_p1 <= BLOCKED_DATA;
    end else begin
      tag_p1      <= tag_nxt;
      cpu_hold_p1 <= cpu_rdata;
      ppu_hold_p1 <= ppu_rdata;
    end
  end

  // Steer synchronous RAM data to the tagged requester, else hold.
  always_comb begin
    if      (tag_p1.cpu_vram) cpu_rdata = vram_rdata;
    else if (tag_p1.cpu_oam)  cpu_rdata = oam_rdata;
    else if (tag_p1.cpu_blk)  cpu_rdata = BLOCKED_DATA;
    else                      cpu_rdata = cpu_hold_p1;
    if      (tag_p1.ppu_vram) ppu_rdata = vram_rdata;
    else if (tag_p1.ppu_oam)  ppu_rdata = oam_rdata;
    else if (tag_p1.ppu_blk)  ppu_rdata = BLOCKED_DATA;
    else                      ppu_rdata = ppu_hold_p1;
  end

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Directed plus randomized bench for vram_oam_arbiter with behavioural RAM/bus models.
module tb_vram_oam_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [1:0]  ppu_mode;
  logic        lcd_en, ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        dma_src_rd;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_src_rdata = 8'h00;
  logic        dma_active;
  logic [12:0] vram_addr;
  logic        vram_rd, vram_wr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic [7:0]  oam_addr;
  logic        oam_rd, oam_wr;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata = 8'h00;

  logic [7:0] vram_mem [0:8191] = '{default: 8'h00};
  logic [7:0] oam_mem  [0:255]  = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_oam_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ppu_mode(ppu_mode), .lcd_en(lcd_en), .ppu_rd(ppu_rd),
    .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .dma_src_rd(dma_src_rd), .dma_src_addr(dma_src_addr),
    .dma_src_rdata(dma_src_rdata), .dma_active(dma_active),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_rd(oam_rd), .oam_wr(oam_wr),
    .oam_wdata(oam_wdata), .oam_rdata(oam_rdata)
  );

  // Main-bus source contents: page C1 holds i^5A, other pages a distinct pattern.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h33;
  endfunction

  // Synchronous RAM macros and main-bus read port.
  always @(posedge clk) begin
    if (vram_wr) vram_mem[vram_addr] <= vram_wdata;
    if (vram_rd) vram_rdata <= vram_mem[vram_addr];
    if (oam_wr)  oam_mem[oam_addr] <= oam_wdata;
    if (oam_rd)  oam_rdata <= oam_mem[oam_addr];
    if (dma_src_rd) dma_src_rdata <= src_byte(dma_src_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_rd = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    d = cpu_rdata;
  endtask

  // Reference model state (spec-level memory images and expected read ports).
  logic [7:0] ref_vram [0:8191];
  logic [7:0] ref_oam  [0:159];
  logic [7:0] exp_cpu, exp_ppu, rd;

  function automatic bit is_vram(input logic [15:0] a);
    return a >= 16'h8000 && a <= 16'h9FFF;
  endfunction
  function automatic bit is_oam(input logic [15:0] a);
    return a >= 16'hFE00 && a <= 16'hFE9F;
  endfunction

  initial begin
    int cnt, c1_reads, m, op, sel, psel;
    bit found, lcd, pr, ok;
    logic [15:0] ca, pa;
    logic [7:0] d;

    for (int i = 0; i < 8192; i++) ref_vram[i] = 8'h00;
    for (int i = 0; i < 160; i++)  ref_oam[i]  = 8'h00;

    rst = 1'b1; cpu_addr = 16'h0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = 8'h00;
    ppu_mode = 2'd0; lcd_en = 1'b1; ppu_rd = 0; ppu_addr = 16'h0;
    tick(); tick();
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_ppu_rdata", ppu_rdata, 8'hFF);
    chk("rst_dma_active", dma_active, 1'b0);
    chk("rst_strobes", {vram_rd, vram_wr, oam_rd, oam_wr, dma_src_rd}, 5'b0);
    chk("rst_addrs", {vram_addr, oam_addr, dma_src_addr}, 37'h0);
    rst = 1'b0;
    tick();

    // Mode 0 write/read of VRAM
    cpu_write(16'h8010, 8'hA5); ref_vram[16] = 8'hA5;
    cpu_read(16'h8010, rd);
    chk("m0_vram_read", rd, 8'hA5);

    // Mode 3 write is dropped, read is blocked
    ppu_mode = 2'd3;
    cpu_addr = 16'h8010; cpu_wdata = 8'h3C; cpu_wr = 1'b1;
    #1;
    chk("m3_vram_wr_dropped", vram_wr, 1'b0);
    tick(); cpu_wr = 1'b0;
    cpu_read(16'h8010, rd);
    chk("m3_vram_read_blocked", rd, 8'hFF);
    ppu_mode = 2'd0;
    cpu_read(16'h8010, rd);
    chk("m0_vram_unchanged", rd, 8'hA5);

    // Mode 2: PPU OAM read collides with a locked-out CPU OAM write
    cpu_write(16'hFE00, 8'h11); ref_oam[0] = 8'h11;
    ppu_mode = 2'd2;
    ppu_rd = 1'b1; ppu_addr = 16'hFE00;
    cpu_addr = 16'hFE00; cpu_wdata = 8'h77; cpu_wr = 1'b1;
    #1;
    chk("m2_oam_wr_blocked", oam_wr, 1'b0);
    tick(); idle();
    chk("m2_ppu_oam_read", ppu_rdata, 8'h11);
    ppu_mode = 2'd0;
    cpu_read(16'hFE00, rd);
    chk("m0_oam_unchanged", rd, 8'h11);
    exp_cpu = 8'h11; exp_ppu = 8'h11;

    // Randomized mixed CPU/PPU traffic against the rule model
    for (int it = 0; it < 300; it++) begin
      m   = $urandom_range(0, 3);
      lcd = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ca = 16'h8000 + 16'($urandom_range(0, 63));
        1:       ca = 16'hFE00 + 16'($urandom_range(0, 159));
        2:       ca = 16'hFEA0 + 16'($urandom_range(0, 95));
        default: ca = 16'h9FC0 + 16'($urandom_range(0, 63));
      endcase
      pr   = 1'($urandom_range(0, 1));
      psel = $urandom_range(0, 2);
      case (psel)
        0:       pa = 16'h8000 + 16'($urandom_range(0, 63));
        1:       pa = 16'hFE00 + 16'($urandom_range(0, 159));
        default: pa = 16'hC000 + 16'($urandom_range(0, 255));
      endcase
      d = 8'($urandom);

      if (lcd && pr) begin
        if (is_vram(pa))     exp_ppu = ref_vram[pa - 16'h8000];
        else if (is_oam(pa)) exp_ppu = ref_oam[pa - 16'hFE00];
        else                 exp_ppu = 8'hFF;
      end
      if (is_vram(ca))     ok = !(lcd && m == 3) && !(lcd && pr && is_vram(pa));
      else if (is_oam(ca)) ok = !(lcd && m >= 2) && !(lcd && pr && is_oam(pa));
      else                 ok = 1'b0;
      if (op == 1) begin
        if (!ok)             exp_cpu = 8'hFF;
        else if (is_vram(ca)) exp_cpu = ref_vram[ca - 16'h8000];
        else                 exp_cpu = ref_oam[ca - 16'hFE00];
      end

      ppu_mode = 2'(m); lcd_en = lcd;
      ppu_rd = pr; ppu_addr = pa;
      cpu_addr = ca; cpu_wdata = d;
      cpu_rd = (op == 1); cpu_wr = (op == 2);
      tick(); idle();
      if (op == 2 && ok) begin
        if (is_vram(ca)) ref_vram[ca - 16'h8000] = d;
        else             ref_oam[ca - 16'hFE00] = d;
      end
      chk($sformatf("rnd%0d_cpu_rdata", it), cpu_rdata, exp_cpu);
      chk($sformatf("rnd%0d_ppu_rdata", it), ppu_rdata, exp_ppu);
    end
    for (int i = 0; i < 64; i += 9)
      chk($sformatf("rnd_vram_img_%0d", i), vram_mem[i], ref_vram[i]);

    // Full OAM DMA from page C1
    ppu_mode = 2'd1; lcd_en = 1'b1; idle();
    cpu_write(16'hFF46, 8'hC1);
    cnt = 0;
    while (dma_active && cnt < 1000) begin
      if (cnt == 10) begin cpu_addr = 16'hFE10; cpu_rd = 1'b1; end
      tick();
      if (cnt == 10) begin
        cpu_rd = 1'b0;
        chk("dma_cpu_oam_blocked", cpu_rdata, 8'hFF);
      end
      cnt++;
    end
    chk("dma_active_cycles", cnt, 321);
    for (int i = 0; i < 160; i++) begin
      ref_oam[i] = 8'(i) ^ 8'h5A;
      chk($sformatf("dma_c1_oam_%0d", i), oam_mem[i], ref_oam[i]);
    end

    // Restart at byte 50 with page D0
    cpu_write(16'hFF46, 8'hC1);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (dma_src_rd && dma_src_addr == 16'hC132) found = 1'b1;
      else tick();
    end
    chk("restart_reached_byte50", found, 1'b1);
    cpu_write(16'hFF46, 8'hD0);
    cnt = 0; c1_reads = 0;
    while (dma_active && cnt < 1000) begin
      if (dma_src_rd && dma_src_addr[15:8] == 8'hC1) c1_reads++;
      tick();
      cnt++;
    end
    chk("restart_no_c1_reads", c1_reads, 0);
    chk("restart_active_cycles", cnt, 321);
    for (int i = 0; i < 160; i++) begin
      ref_oam[i] = 8'(i) ^ 8'hD0 ^ 8'h33;
      chk($sformatf("restart_d0_oam_%0d", i), oam_mem[i], ref_oam[i]);
    end

    // Async reset at byte 80
    cpu_write(16'hFF46, 8'hC1);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (dma_src_rd && dma_src_addr == 16'hC150) found = 1'b1;
      else tick();
    end
    chk("reset_reached_byte80", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("reset_dma_active", dma_active, 1'b0);
    chk("reset_strobes", {vram_rd, vram_wr, oam_rd, oam_wr, dma_src_rd}, 5'b0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_reset_dma_idle", dma_active, 1'b0);
    chk("post_reset_cpu_rdata", cpu_rdata, 8'hFF);
    chk("post_reset_ppu_rdata", ppu_rdata, 8'hFF);
    for (int i = 0; i < 80; i++) ref_oam[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 160; i++)
      chk($sformatf("reset_oam_%0d", i), oam_mem[i], ref_oam[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
